// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared encodings and timing defaults for the MIPS
// debug-observation blocks (probe selector and step debouncer).
package mips_dbg_pkg;

    // Observation modes driven on the 2-bit mode input; 2'b11 behaves as live.
    typedef enum logic [1:0] {
        MODE_LIVE     = 2'b00,
        MODE_FREEZE   = 2'b01,
        MODE_SCAN     = 2'b10,
        MODE_LIVE_ALT = 2'b11
    } mode_e;

    // Debouncer states: the accepted button level plus a "qualifying" state
    // for each direction while the opposite level is being timed.
    typedef enum logic [1:0] {
        DEB_IDLE_LOW  = 2'b00,
        DEB_WAIT_HIGH = 2'b01,
        DEB_IDLE_HIGH = 2'b10,
        DEB_WAIT_LOW  = 2'b11
    } deb_state_e;

    // 10 ms of stability at 50 MHz before a button level is accepted.
    localparam int DEB_CYCLES_50M = 500000;
    // One second per channel in auto-scan at 50 MHz.
    localparam int SCAN_TICKS_1S  = 50000000;

    // Bits needed for a counter that runs 0..max_count-1 (never below 1).
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// step_debouncer: two-flop synchroniser plus a four-state debounce FSM for a
// raw push-button. Emits one registered pulse per accepted press, i.e. after
// the synchronised input has been high for DEB_CYCLES consecutive clocks.
// Release is qualified the same way but produces no pulse. The pulse rises
// DEB_CYCLES+2 clocks after a clean rising edge on button_in.
// DEB_CYCLES is expected to be at least 2.
module step_debouncer
    import mips_dbg_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_50M
) (
    input  logic clk_50MHz,
    input  logic reset_n,
    input  logic clear,
    input  logic button_in,
    output logic pulse_out
);

    localparam int CNT_W = cnt_width(DEB_CYCLES);
    // The counter holds (samples seen - 1); the sample that would bring it to
    // DEB_CYCLES-1 is the DEB_CYCLES-th stable sample and completes the wait.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);

    logic [1:0]       sync_q, sync_d;
    logic             synced;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    assign synced    = sync_q[1];
    assign pulse_out = pulse_q;

    // Next-state logic: synchroniser shift, debounce transitions and pulse.
    always_comb begin
        sync_d  = {sync_q[0], button_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (clear) begin
            state_d = DEB_IDLE_LOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DEB_IDLE_LOW: begin
                    if (synced) begin
                        state_d = DEB_WAIT_HIGH;
                        cnt_d   = '0;
                    end
                end
                DEB_WAIT_HIGH: begin
                    if (!synced) begin
                        state_d = DEB_IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = DEB_IDLE_HIGH;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEB_IDLE_HIGH: begin
                    if (!synced) begin
                        state_d = DEB_WAIT_LOW;
                        cnt_d   = '0;
                    end
                end
                DEB_WAIT_LOW: begin
                    if (synced) begin
                        state_d = DEB_IDLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = DEB_IDLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = DEB_IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register for synchroniser, FSM, counter and pulse.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            state_q <= DEB_IDLE_LOW;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/debug_probe_selector.sv
// debug_probe_selector: drives one of NUM_CH probe channels to the LED bank
// as a registered value, in live, frozen-on-step or auto-scan mode, and
// generates the debounced single-step pulse that clocks the processor.
// Optional feature macro STEP_COUNT_EN: adds a 16-bit step counter output,
// which freeze mode also shows when sel == NUM_CH.
module debug_probe_selector
    import mips_dbg_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int WIDTH      = 16,
    parameter int SEL_W      = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_50M,
    parameter int SCAN_TICKS = SCAN_TICKS_1S
) (
    input  logic                    clk_50MHz,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    push_step,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] probes,
    output logic                    step_pulse,
    output logic [WIDTH-1:0]        probe_out,
    output logic [SEL_W-1:0]        ch_idx,
    output logic                    scan_tick
`ifdef STEP_COUNT_EN
    ,
    output logic [15:0]             step_count
`endif
);

    localparam int SCAN_CW = cnt_width(SCAN_TICKS);
    localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_TICKS - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(NUM_CH - 1);

    logic               scan_mode;
    logic               freeze_mode;
    logic               capture;
    logic [SEL_W-1:0]   eff;
    logic [WIDTH-1:0]   eff_val;

    logic [SCAN_CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
    logic               scan_tick_q, scan_tick_d;
    logic [WIDTH-1:0]   probe_out_q, probe_out_d;
    logic [SEL_W-1:0]   ch_idx_q, ch_idx_d;

    // Debounced step pulse; also the processor's single-step clock enable.
    step_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_debouncer (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .clear     (clear),
        .button_in (push_step),
        .pulse_out (step_pulse)
    );

    assign scan_mode   = (mode == MODE_SCAN);
    assign freeze_mode = (mode == MODE_FREEZE);
    // clear outranks a coincident step: no capture in that cycle.
    assign capture     = step_pulse && !clear;

`ifdef STEP_COUNT_EN
    logic [15:0] step_count_q, step_count_d;

    // Step counter: one count per step pulse, wraps naturally at 16 bits.
    always_comb begin
        step_count_d = step_count_q;
        if (clear) begin
            step_count_d = '0;
        end else if (step_pulse) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    // Step counter register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign step_count = step_count_q;
`endif

    // Auto-scan timer: dwell SCAN_TICKS cycles per channel; the index is kept
    // across mode changes while the dwell counter restarts on re-entry.
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        scan_idx_d  = scan_idx_q;
        scan_tick_d = 1'b0;
        if (clear) begin
            scan_cnt_d = '0;
            scan_idx_d = '0;
        end else if (scan_mode) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d  = '0;
                scan_tick_d = 1'b1;
                scan_idx_d  = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end else begin
            scan_cnt_d = '0;
        end
    end

    // Effective channel and its value; out-of-range selects read as zero.
    // A captured value is the state seen during the pulse cycle, i.e. before
    // the processor executes the step; the step counter is the exception and
    // shows the count including the step being captured.
    always_comb begin
        eff     = scan_mode ? scan_idx_q : sel;
        eff_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff == SEL_W'(k)) begin
                eff_val = probes[k*WIDTH +: WIDTH];
            end
        end
`ifdef STEP_COUNT_EN
        if (freeze_mode && (32'(sel) == NUM_CH)) begin
            eff_val = WIDTH'(step_count_d);
        end
`endif
    end

    // Output register update: live/scan track every cycle, freeze only on a step.
    always_comb begin
        probe_out_d = probe_out_q;
        ch_idx_d    = ch_idx_q;
        if (!freeze_mode || capture) begin
            probe_out_d = eff_val;
            ch_idx_d    = eff;
        end
    end

    // Registers for scan state and the LED-facing outputs.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            scan_tick_q <= 1'b0;
            probe_out_q <= '0;
            ch_idx_q    <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            scan_tick_q <= scan_tick_d;
            probe_out_q <= probe_out_d;
            ch_idx_q    <= ch_idx_d;
        end
    end

    assign probe_out = probe_out_q;
    assign ch_idx    = ch_idx_q;
    assign scan_tick = scan_tick_q;

endmodule
